// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and configuration check for the pipelined carry-lookahead adder.
package pipelined_cla_adder_pkg;

  localparam int PIPE_STAGES = 3;
  localparam int LATENCY     = 3;

  function automatic bit pg_cfg_legal(input int width, input int group);
    return ((group == 2) || (group == 4)) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_pg_group.sv
// Group generate/propagate over N bits: gg = carry out of the group with zero carry in, pp = AND of p.
module pg_group #(
  parameter int N = 4
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  output logic         gg,
  output logic         pp
);

  always_comb begin
    gg = g[0];
    for (int i = 1; i < N; i++) begin
      gg = g[i] | (p[i] & gg);
    end
    pp = &p;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// 3-stage CLA add/sub (bit P/G -> group GG/PP -> carries/sum); result 3 edges after accept.
// One global enable: every stage holds while out_valid & ~out_ready, and in_ready drops.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             gg,
  output logic             pp
);

  localparam int NG = WIDTH / GROUP;

  if (!pg_cfg_legal(WIDTH, GROUP)) begin : g_cfg_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP and GROUP must be 2 or 4");
  end

  logic             en;
  logic [WIDTH-1:0] bb;

  logic [WIDTH-1:0] p1_d, p1_q, g1_d, g1_q;
  logic             c01_d, c01_q, v1_d, v1_q;

  logic [WIDTH-1:0] p2_d, p2_q, g2_d, g2_q;
  logic [NG-1:0]    ggk2_d, ggk2_q, ppk2_d, ppk2_q;
  logic             c02_d, c02_q, v2_d, v2_q;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q, gg_d, gg_q, pp_d, pp_q, v3_d, v3_q;

  logic [NG-1:0]    grp_gg, grp_pp;
  logic             blk_gg, blk_pp;
  logic [NG:0]      gcar;
  logic [WIDTH-1:0] bcar;
  logic             run;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    pg_group #(.N(GROUP)) u_pg (
      .g  (g1_q[k*GROUP +: GROUP]),
      .p  (p1_q[k*GROUP +: GROUP]),
      .gg (grp_gg[k]),
      .pp (grp_pp[k])
    );
  end

  // Second level of lookahead over the registered group terms gives the block gg/pp.
  pg_group #(.N(NG)) u_pg_blk (
    .g  (ggk2_q),
    .p  (ppk2_q),
    .gg (blk_gg),
    .pp (blk_pp)
  );

  always_comb begin
    en = ~v3_q | out_ready;
    bb = sub ? ~b : b;

    p1_d   = en ? (a ^ bb) : p1_q;
    g1_d   = en ? (a & bb) : g1_q;
    c01_d  = en ? (sub ? 1'b1 : cin) : c01_q;
    v1_d   = en ? in_valid : v1_q;

    p2_d   = en ? p1_q   : p2_q;
    g2_d   = en ? g1_q   : g2_q;
    ggk2_d = en ? grp_gg : ggk2_q;
    ppk2_d = en ? grp_pp : ppk2_q;
    c02_d  = en ? c01_q  : c02_q;
    v2_d   = en ? v1_q   : v2_q;

    gcar[0] = c02_q;
    for (int k = 0; k < NG; k++) begin
      gcar[k+1] = ggk2_q[k] | (ppk2_q[k] & gcar[k]);
    end

    // Bit carries only ripple inside a group, seeded from that group's lookahead carry.
    bcar = '0;
    run  = 1'b0;
    for (int k = 0; k < NG; k++) begin
      run = gcar[k];
      for (int i = 0; i < GROUP; i++) begin
        bcar[k*GROUP+i] = run;
        run = g2_q[k*GROUP+i] | (p2_q[k*GROUP+i] & run);
      end
    end

    sum_d  = en ? (p2_q ^ bcar) : sum_q;
    cout_d = en ? gcar[NG] : cout_q;
    ovf_d  = en ? (bcar[WIDTH-1] ^ gcar[NG]) : ovf_q;
    gg_d   = en ? blk_gg : gg_q;
    pp_d   = en ? blk_pp : pp_q;
    v3_d   = en ? v2_q : v3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q   <= '0;
      g1_q   <= '0;
      c01_q  <= 1'b0;
      v1_q   <= 1'b0;
      p2_q   <= '0;
      g2_q   <= '0;
      ggk2_q <= '0;
      ppk2_q <= '0;
      c02_q  <= 1'b0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      gg_q   <= 1'b0;
      pp_q   <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      p1_q   <= p1_d;
      g1_q   <= g1_d;
      c01_q  <= c01_d;
      v1_q   <= v1_d;
      p2_q   <= p2_d;
      g2_q   <= g2_d;
      ggk2_q <= ggk2_d;
      ppk2_q <= ppk2_d;
      c02_q  <= c02_d;
      v2_q   <= v2_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      gg_q   <= gg_d;
      pp_q   <= pp_d;
      v3_q   <= v3_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = v3_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign gg        = gg_q;
  assign pp        = pp_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench: three widths driven in lockstep; monitors pop expected results on each output transfer.
module tb_pipelined_cla_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        gg;
    logic        pp;
    int          stamp;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin, sub;
  logic [31:0] a, b;

  logic        ir8, ir16, ir32, ov8, ov16, ov32;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;
  logic        co8, co16, co32, of8, of16, of32;
  logic        gg8, gg16, gg32, pp8, pp16, pp32;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q8[$], q16[$], q32[$];

  pipelined_cla_adder #(.WIDTH(8), .GROUP(2)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8),
    .ovf(of8), .gg(gg8), .pp(pp8));

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16),
    .ovf(of16), .gg(gg16), .pp(pp16));

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32),
    .ovf(of32), .gg(gg32), .pp(pp32));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] s, input logic co, input logic of,
                              input logic g, input logic p);
    exp_t e;
    e.sum = s; e.cout = co; e.ovf = of; e.gg = g; e.pp = p; e.stamp = 0; e.lat = 1'b0;
    return e;
  endfunction

  // Reference from whole-word arithmetic on 64-bit values, independent of any P/G structure.
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb,
                                 input logic tc, input logic ts, input int w);
    exp_t e;
    logic [63:0] mask, lowm, aa, bb, full, low, c0;
    mask = (64'd1 << w) - 64'd1;
    lowm = mask >> 1;
    aa   = {32'd0, ta} & mask;
    bb   = (ts ? ~{32'd0, tb} : {32'd0, tb}) & mask;
    c0   = ts ? 64'd1 : {63'd0, tc};
    full = aa + bb + c0;
    low  = (aa & lowm) + (bb & lowm) + c0;
    e = mk(full[31:0] & mask[31:0], full[w], low[w-1] ^ full[w], 1'b0, 1'b0);
    full = aa + bb;
    e.gg = full[w];
    e.pp = ((aa ^ bb) == mask);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [31:0] s,
                     input logic co, input logic of, input logic g, input logic p);
    checks++;
    if ({s, co, of, g, p} !== {e.sum, e.cout, e.ovf, e.gg, e.pp}) begin
      errors++;
      $display("FAIL %s got sum=%h cout=%b ovf=%b gg=%b pp=%b want sum=%h cout=%b ovf=%b gg=%b pp=%b",
               tag, s, co, of, g, p, e.sum, e.cout, e.ovf, e.gg, e.pp);
    end
    if (e.lat) begin
      checks++;
      if (cyc - e.stamp != 3) begin
        errors++;
        $display("FAIL %s_latency got=%0d want=3", tag, cyc - e.stamp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ov8 && out_ready) begin
      if (q8.size() == 0) begin
        checks++; errors++; $display("FAIL w8_unexpected got sum=%h want none", s8);
      end else cmp("w8", q8.pop_front(), {24'd0, s8}, co8, of8, gg8, pp8);
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16 && out_ready) begin
      if (q16.size() == 0) begin
        checks++; errors++; $display("FAIL w16_unexpected got sum=%h want none", s16);
      end else cmp("w16", q16.pop_front(), {16'd0, s16}, co16, of16, gg16, pp16);
    end
  end

  always @(negedge clk) begin
    if (!rst && ov32 && out_ready) begin
      if (q32.size() == 0) begin
        checks++; errors++; $display("FAIL w32_unexpected got sum=%h want none", s32);
      end else cmp("w32", q32.pop_front(), s32, co32, of32, gg32, pp32);
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                      input logic ts, input exp_t e16, input bit lat);
    bit done;
    exp_t e;
    done = 1'b0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ir16) begin
        done = 1'b1;
        e = e16; e.stamp = cyc; e.lat = lat;
        q16.push_back(e);
        q8.push_back(model(ta, tb, tc, ts, 8));
        q32.push_back(model(ta, tb, tc, ts, 32));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++; $display("FAIL send_timeout got in_ready=0 want 1");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_drained(input string name);
    chk({name, "_q8_empty"}, q8.size(), 0);
    chk({name, "_q16_empty"}, q16.size(), 0);
    chk({name, "_q32_empty"}, q32.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0; a = '0; b = '0;
    idle(2);
    chk("rst_out_valid", {ov8, ov16, ov32}, 3'b000);
    chk("rst_sum16", s16, 0);
    chk("rst_flags16", {co16, of16, gg16, pp16}, 4'b0000);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {ir8, ir16, ir32}, 3'b111);

    // Directed vectors, hand-computed for the 16-bit instance.
    send(32'h00FF, 32'h0001, 1'b0, 1'b0, mk(32'h0100, 0, 0, 0, 0), 1'b1);
    send(32'hFFFF, 32'h0001, 1'b0, 1'b0, mk(32'h0000, 1, 0, 1, 0), 1'b0);
    send(32'hFFFF, 32'h0000, 1'b1, 1'b0, mk(32'h0000, 1, 0, 0, 1), 1'b0);
    send(32'h0005, 32'h0007, 1'b0, 1'b1, mk(32'hFFFE, 0, 0, 0, 0), 1'b0);
    send(32'h8000, 32'h0001, 1'b1, 1'b1, mk(32'h7FFF, 1, 1, 1, 0), 1'b0);
    idle(8);
    check_drained("directed");

    // Back-to-back stream with a 4-cycle output stall after the first result.
    fork
      begin
        send(32'h0001, 32'h0002, 1'b0, 1'b0, mk(32'h0003, 0, 0, 0, 0), 1'b0);
        send(32'h1234, 32'h4321, 1'b0, 1'b0, mk(32'h5555, 0, 0, 0, 0), 1'b0);
        send(32'h7FFF, 32'h0001, 1'b0, 1'b0, mk(32'h8000, 0, 1, 0, 0), 1'b0);
        send(32'hAAAA, 32'h5555, 1'b1, 1'b0, mk(32'h0000, 1, 0, 0, 1), 1'b0);
        send(32'h0000, 32'h0000, 1'b0, 1'b1, mk(32'h0000, 1, 0, 0, 1), 1'b0);
      end
      begin
        bit got;
        logic [15:0] snap;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
          @(negedge clk);
          got = ov16;
        end
        chk("stall_first_valid", {31'd0, got}, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap = s16;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("stall_hold_sum", {16'd0, s16}, {16'd0, snap});
          chk("stall_in_ready", {31'd0, ir16}, 0);
          chk("stall_out_valid", {31'd0, ov16}, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(10);
    check_drained("stall");

    // Reset with three ops in flight discards them without a clock edge.
    send(32'h1111, 32'h2222, 1'b0, 1'b0, mk(32'h3333, 0, 0, 0, 0), 1'b0);
    send(32'h4444, 32'h4444, 1'b0, 1'b0, mk(32'h8888, 0, 1, 0, 0), 1'b0);
    send(32'h0010, 32'h0001, 1'b0, 1'b1, mk(32'h000F, 1, 0, 1, 0), 1'b0);
    chk("pre_rst_valid", {31'd0, ov16}, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", {ov8, ov16, ov32}, 3'b000);
    q8.delete(); q16.delete(); q32.delete();
    idle(2);
    rst = 1'b0;
    send(32'h0F0F, 32'hF0F0, 1'b1, 1'b0, mk(32'h0000, 1, 0, 0, 1), 1'b1);
    idle(6);
    check_drained("post_rst");

    // Random traffic with random input valid and output backpressure.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom;
      cin = $urandom_range(0, 1) == 1;
      sub = $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (in_valid && ir16) begin
        q8.push_back(model(a, b, cin, sub, 8));
        q16.push_back(model(a, b, cin, sub, 16));
        q32.push_back(model(a, b, cin, sub, 32));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(10);
    check_drained("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
